// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES slice per stage
// Optional signed overflow output enabled by macro CLA_PIPE_OVERFLOW_EN.
module pipelined_cla_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_add1,
   input  logic [WIDTH-1:0] i_add2,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH:0]   o_result,
   output logic             o_overflow
);

   localparam int NST   = (STAGES < 1) ? 1 : STAGES;
   localparam int SLICE = WIDTH / NST;
   localparam int BTOT  = SLICE * NST * (NST - 1) / 2;
   localparam int BW    = (BTOT < 1) ? 1 : BTOT;
   localparam int NS    = (NST > 1) ? NST - 1 : 1;
   localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

   if (STAGES < 1 || (WIDTH % NST) != 0) begin : g_bad_cfg
      $error("pipelined_cla_addsub: STAGES must be >= 1 and divide WIDTH");
   end

   // Unconsumed B slices shrink by one slice per stage; packed back to back in r_brem.
   function automatic int rem_off(input int k);
      return SLICE * (k * (NST - 1) - (k * (k - 1)) / 2);
   endfunction

   function automatic logic [SLICE:0] cla_carry(input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b,
                                                input logic             cin);
      logic [SLICE:0] c;
      c[0] = cin;
      for (int i = 0; i < SLICE; i++) begin
         c[i+1] = (a[i] & b[i]) | ((a[i] | b[i]) & c[i]);
      end
      return c;
   endfunction

   logic [WIDTH-1:0] r_d [NST];
   logic [NST-1:0]   r_v;
   logic [NST-1:0]   r_c;
   logic [NS-1:0]    r_sub;
   logic [BW-1:0]    r_brem;

   logic [WIDTH-1:0] w_d_nxt [NST];
   logic [NST-1:0]   w_c_nxt;
   logic [NS-1:0]    w_sub_nxt;
   logic [BW-1:0]    w_brem_nxt;
   logic             w_adv;

   assign w_adv   = !r_v[NST-1] || i_ready;
   assign o_ready = w_adv;
   assign o_valid = r_v[NST-1];

`ifdef CLA_PIPE_OVERFLOW_EN
   logic w_ovf_nxt;
   logic r_ovf;
`endif

   for (genvar k = 0; k < NST; k++) begin : g_stage
      logic [WIDTH-k*SLICE-1:0] w_bsrc;
      logic [WIDTH-1:0]         w_dsrc;
      logic                     w_sub;
      logic                     w_cin;
      logic [SLICE-1:0]         w_a;
      logic [SLICE-1:0]         w_b;
      logic [SLICE-1:0]         w_s;
      logic [SLICE:0]           w_c;

      if (k == 0) begin : g_in
         assign w_bsrc = i_add2;
         assign w_dsrc = i_add1;
         assign w_sub  = i_sub;
         assign w_cin  = i_sub;
      end else begin : g_in
         localparam int OFF = rem_off(k - 1);
         assign w_bsrc = r_brem[OFF +: WIDTH-k*SLICE];
         assign w_dsrc = r_d[k-1];
         assign w_sub  = r_sub[k-1];
         assign w_cin  = r_c[k-1];
      end

      // r_d holds finished sum slices below slice k and raw A above it.
      assign w_a = w_dsrc[k*SLICE +: SLICE];
      assign w_b = w_bsrc[SLICE-1:0] ^ {SLICE{w_sub}};
      assign w_c = cla_carry(w_a, w_b, w_cin);
      assign w_s = w_a ^ w_b ^ w_c[SLICE-1:0];

      assign w_d_nxt[k] = (w_dsrc & ~(SMASK << (k * SLICE))) | (WIDTH'(w_s) << (k * SLICE));
      assign w_c_nxt[k] = w_c[SLICE];

      if (k < NST - 1) begin : g_fwd
         localparam int OFF = rem_off(k);
         assign w_sub_nxt[k] = w_sub;
         assign w_brem_nxt[OFF +: WIDTH-(k+1)*SLICE] = w_bsrc[WIDTH-k*SLICE-1:SLICE];
      end

`ifdef CLA_PIPE_OVERFLOW_EN
      if (k == NST - 1) begin : g_ovf
         assign w_ovf_nxt = w_c[SLICE] ^ w_c[SLICE-1];
      end
`endif
   end

   if (NST == 1) begin : g_single
      assign w_sub_nxt  = 1'b0;
      assign w_brem_nxt = '0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_v    <= '0;
         r_c    <= '0;
         r_sub  <= '0;
         r_brem <= '0;
         for (int k = 0; k < NST; k++) begin
            r_d[k] <= '0;
         end
      end else if (w_adv) begin
         r_v[0] <= i_valid;
         for (int k = 1; k < NST; k++) begin
            r_v[k] <= r_v[k-1];
         end
         r_c    <= w_c_nxt;
         r_sub  <= w_sub_nxt;
         r_brem <= w_brem_nxt;
         for (int k = 0; k < NST; k++) begin
            r_d[k] <= w_d_nxt[k];
         end
      end
   end

   assign o_result = {r_c[NST-1], r_d[NST-1]};

`ifdef CLA_PIPE_OVERFLOW_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_ovf <= w_ovf_nxt;
      end
   end
   assign o_overflow = r_ovf;
`else
   assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - randomized self-checking bench with an arithmetic reference model
module tb_pipelined_cla_addsub;
   localparam int W = 16;
`ifdef CLA_PIPE_OVERFLOW_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i_valid = 1'b0;
   logic         i_sub = 1'b0;
   logic         i_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         o_ready;
   logic         o_valid;
   logic [W:0]   o_result;
   logic         o_overflow;

   pipelined_cla_addsub #(.WIDTH(W), .STAGES(4)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_add1     (a),
      .i_add2     (b),
      .i_sub      (i_sub),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_result   (o_result),
      .o_overflow (o_overflow)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_out = 0;
   logic acc_flag = 1'b0;
   logic prev_stall = 1'b0;
   logic [W:0] prev_res = '0;
   logic prev_ovf = 1'b0;
   logic [W+1:0] expq[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp_v, cyc);
      end
   endtask

   // {overflow, carry/no-borrow, sum} from plain integer arithmetic
   function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
      int unsigned ux = x;
      int unsigned uy = y;
      logic [W:0] r;
      logic ov;
      if (!s) begin
         r  = (W+1)'(ux + uy);
         ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end else begin
         r  = {(ux >= uy), W'(ux - uy)};
         ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      return {ov & OVF_ON, r};
   endfunction

   always @(negedge clk) begin
      logic [W+1:0] e;
      if (rst) begin
         expq.delete();
         prev_stall = 1'b0;
         acc_flag = 1'b0;
         chk("rst_o_valid", o_valid, 0);
         chk("rst_o_ready", o_ready, 1);
         chk("rst_o_result", o_result, 0);
      end else begin
         chk("o_ready_rule", o_ready, !o_valid || i_ready);
         if (prev_stall) begin
            chk("hold_valid", o_valid, 1);
            chk("hold_result", o_result, prev_res);
            chk("hold_ovf", o_overflow, prev_ovf);
         end
         if (o_valid && i_ready) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %0h expected none at cycle %0d", o_result, cyc);
            end else begin
               e = expq.pop_front();
               chk("result", o_result, e[W:0]);
               chk("overflow", o_overflow, e[W+1]);
               n_out++;
            end
         end
         acc_flag = i_valid && o_ready;
         if (acc_flag) expq.push_back(ref_model(a, b, i_sub));
         prev_stall = o_valid && !i_ready;
         prev_res = o_result;
         prev_ovf = o_overflow;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic ts, input logic [W:0] er, input logic eo);
      int n;
      a = ta; b = tb_v; i_sub = ts; i_valid = 1'b1; i_ready = 1'b1;
      step();
      chk({name, "_accept"}, acc_flag, 1);
      i_valid = 1'b0;
      n = 1;
      while (!o_valid && n < 20) begin
         step();
         n++;
      end
      chk({name, "_latency"}, n, 4);
      chk({name, "_result"}, o_result, er);
      chk({name, "_ovf"}, o_overflow, eo);
      step();
      step();
   endtask

   task automatic drain();
      int n = 0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      while ((expq.size() != 0 || o_valid) && n < 100) begin
         step();
         n++;
      end
      chk("drain_empty", expq.size(), 0);
   endtask

   initial begin
      int c, idx, stalls, n0, acc, stale;
      logic need_new;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_o_valid", o_valid, 0);
      chk("reset_o_result", o_result, 0);
      chk("reset_o_overflow", o_overflow, 0);
      chk("reset_o_ready", o_ready, 1);
      rst = 1'b0;
      #1;
      chk("post_reset_o_ready", o_ready, 1);
      step();

      directed("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 17'h1_0000, 1'b0);
      directed("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 17'h0_8000, OVF_ON);
      directed("sub_5_7",    16'h0005, 16'h0007, 1'b1, 17'h0_FFFE, 1'b0);
      directed("sub_7_5",    16'h0007, 16'h0005, 1'b1, 17'h1_0002, 1'b0);
      directed("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 17'h1_7FFF, OVF_ON);

      c = 0; idx = 0; stalls = 0; need_new = 1'b1; n0 = n_out;
      while (idx < 8 && c < 100) begin
         i_ready = !(c >= 3 && c <= 5);
         i_valid = 1'b1;
         if (need_new) begin
            a = pick(); b = pick(); i_sub = 1'($urandom);
         end
         step();
         need_new = acc_flag;
         if (acc_flag) idx++;
         else stalls++;
         c++;
      end
      drain();
      chk("burst_outputs", n_out - n0, 8);
      chk("burst_stall_cycles", stalls, 2);

      i_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = pick(); b = pick(); i_sub = 1'($urandom); i_valid = 1'b1;
         step();
      end
      i_valid = 1'b0;
      step();
      chk("inflight_valid", o_valid, 1);
      rst = 1'b1;
      #1;
      chk("midrst_o_valid", o_valid, 0);
      chk("midrst_o_result", o_result, 0);
      chk("midrst_o_overflow", o_overflow, 0);
      chk("midrst_o_ready", o_ready, 1);
      step();
      rst = 1'b0;
      #1;
      chk("release_o_ready", o_ready, 1);
      stale = 0;
      repeat (8) begin
         step();
         if (o_valid) stale++;
      end
      chk("no_stale_results", stale, 0);
      directed("after_rst", 16'h1234, 16'h0FED, 1'b0, 17'h0_2221, 1'b0);

      acc = 0; c = 0;
      while (acc < 2000 && c < 20000) begin
         a = pick(); b = pick(); i_sub = 1'($urandom);
         i_valid = ($urandom_range(0, 9) < 7);
         i_ready = ($urandom_range(0, 9) < 7);
         step();
         if (acc_flag) acc++;
         c++;
      end
      chk("random_accepted", acc, 2000);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
